// File: rtl/game_screen_ctl.sv
// game_screen_ctl: round state machine, score keeping and frame-aligned
// selection of one of four pre-rendered VGA streams for the penalty game.
// Optional build macro: MOUSE_DEBOUNCE_EN (filters mouse_left before click
// detection; filter length set by DEBOUNCE_CYC).
module game_screen_ctl #(
    parameter int RGB_W         = 12,
    parameter int COORD_W       = 12,
    parameter int SHOT_FRAMES   = 60,
    parameter int RESULT_FRAMES = 120,
    parameter int ROUNDS        = 5,
    parameter int SAVE_RADIUS   = 48,
    parameter int DEBOUNCE_CYC  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mouse_left,
    input  logic [COORD_W-1:0]            xpos,
    input  logic [COORD_W-1:0]            ypos,
    input  logic [COORD_W-1:0]            keeper_x,
    input  logic [3:0]                    vs_in,
    input  logic [3:0]                    hs_in,
    input  logic [4*RGB_W-1:0]            rgb_in,
    output logic                          vs,
    output logic                          hs,
    output logic [RGB_W-1:0]              rgb,
    output logic [1:0]                    state,
    output logic [COORD_W-1:0]            aim_x,
    output logic [COORD_W-1:0]            aim_y,
    output logic                          goal,
    output logic [$clog2(ROUNDS+1)-1:0]   goals,
    output logic [$clog2(ROUNDS+1)-1:0]   round_cnt
);

    localparam int FMAX = (SHOT_FRAMES > RESULT_FRAMES) ? SHOT_FRAMES : RESULT_FRAMES;
    localparam int FW   = $clog2(FMAX + 1);
    localparam int GW   = $clog2(ROUNDS + 1);

    localparam logic [FW-1:0]      FRAME_SAT = FMAX[FW-1:0];
    localparam logic [FW-1:0]      SHOT_N    = SHOT_FRAMES[FW-1:0];
    localparam logic [FW-1:0]      RESULT_N  = RESULT_FRAMES[FW-1:0];
    localparam logic [GW-1:0]      ROUNDS_N  = ROUNDS[GW-1:0];
    localparam logic [COORD_W:0]   SAVE_R    = SAVE_RADIUS[COORD_W:0];

    typedef enum logic [1:0] {
        ST_START  = 2'd0,
        ST_AIM    = 2'd1,
        ST_SHOT   = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    state_t              r_state, w_state_nx;
    logic [1:0]          r_sel;
    logic [FW-1:0]       r_cnt, w_cnt_nx, w_cnt_inc;
    logic [COORD_W-1:0]  r_aim_x, r_aim_y, w_aim_x_nx, w_aim_y_nx;
    logic                r_goal, w_goal_nx, w_goal_eval;
    logic [GW-1:0]       r_goals, r_rounds, w_goals_nx, w_rounds_nx;
    logic [GW-1:0]       w_goals_inc, w_rounds_inc;
    logic [COORD_W:0]    w_diff;
    logic                r_ml_prev, r_vs0_prev;
    logic                w_ml, w_click, w_tick;
    logic                r_vs, r_hs;
    logic [RGB_W-1:0]    r_rgb;

`ifdef MOUSE_DEBOUNCE_EN
    localparam int          DW      = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);

    logic          r_ml_filt;
    logic [DW-1:0] r_db_cnt;

    // Filtered button follows the raw level only after DEBOUNCE_CYC
    // consecutive differing samples; resets high so a held button is inert.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ml_filt <= 1'b1;
            r_db_cnt  <= '0;
        end else if (mouse_left != r_ml_filt) begin
            if (r_db_cnt == DB_LAST) begin
                r_ml_filt <= mouse_left;
                r_db_cnt  <= '0;
            end else begin
                r_db_cnt  <= r_db_cnt + 1'b1;
            end
        end else begin
            r_db_cnt <= '0;
        end
    end

    assign w_ml = r_ml_filt;
`else
    // Debounce length has no effect when the filter is not built.
    if (DEBOUNCE_CYC < 1) begin : g_db_unused
    end

    assign w_ml = mouse_left;
`endif

    assign w_click = w_ml & ~r_ml_prev;
    assign w_tick  = vs_in[0] & ~r_vs0_prev;

    // Edge detectors; both reset high so levels held through reset give no pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ml_prev  <= 1'b1;
            r_vs0_prev <= 1'b1;
        end else begin
            r_ml_prev  <= w_ml;
            r_vs0_prev <= vs_in[0];
        end
    end

    // Saturating increments and the keeper-distance test (larger minus smaller).
    always_comb begin
        w_cnt_inc    = (r_cnt == FRAME_SAT) ? r_cnt : r_cnt + 1'b1;
        w_goals_inc  = (r_goals == ROUNDS_N) ? r_goals : r_goals + 1'b1;
        w_rounds_inc = (r_rounds == ROUNDS_N) ? r_rounds : r_rounds + 1'b1;
        if (r_aim_x >= keeper_x)
            w_diff = {1'b0, r_aim_x} - {1'b0, keeper_x};
        else
            w_diff = {1'b0, keeper_x} - {1'b0, r_aim_x};
        w_goal_eval = (w_diff > SAVE_R);
    end

    // Round state machine: next state, counters, aim latch and score.
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_aim_x_nx  = r_aim_x;
        w_aim_y_nx  = r_aim_y;
        w_goal_nx   = r_goal;
        w_goals_nx  = r_goals;
        w_rounds_nx = r_rounds;
        case (r_state)
            ST_START: begin
                if (w_click) begin
                    w_goals_nx  = '0;
                    w_rounds_nx = '0;
                    w_cnt_nx    = '0;
                    w_state_nx  = ST_AIM;
                end
            end
            ST_AIM: begin
                w_cnt_nx = '0;
                if (w_click) begin
                    w_aim_x_nx = xpos;
                    w_aim_y_nx = ypos;
                    w_state_nx = ST_SHOT;
                end
            end
            ST_SHOT: begin
                if (w_tick) begin
                    if (w_cnt_inc >= SHOT_N) begin
                        w_goal_nx  = w_goal_eval;
                        if (w_goal_eval)
                            w_goals_nx = w_goals_inc;
                        w_cnt_nx   = '0;
                        w_state_nx = ST_RESULT;
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end
            end
            default: begin
                // A click skips the rest of the result hold.
                if (w_click || (w_tick && (w_cnt_inc >= RESULT_N))) begin
                    w_rounds_nx = w_rounds_inc;
                    w_cnt_nx    = '0;
                    w_state_nx  = (w_rounds_inc == ROUNDS_N) ? ST_START : ST_AIM;
                end else if (w_tick) begin
                    w_cnt_nx = w_cnt_inc;
                end
            end
        endcase
    end

    // Game state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_START;
            r_cnt    <= '0;
            r_aim_x  <= '0;
            r_aim_y  <= '0;
            r_goal   <= 1'b0;
            r_goals  <= '0;
            r_rounds <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_aim_x  <= w_aim_x_nx;
            r_aim_y  <= w_aim_y_nx;
            r_goal   <= w_goal_nx;
            r_goals  <= w_goals_nx;
            r_rounds <= w_rounds_nx;
        end
    end

    // Screen select follows the state only at frame start, so frames never tear.
    always_ff @(posedge clk) begin
        if (rst)
            r_sel <= 2'd0;
        else if (w_tick)
            r_sel <= r_state;
    end

    // Registered stream mux: fixed one-cycle latency from the selected source.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs  <= 1'b0;
            r_hs  <= 1'b0;
            r_rgb <= '0;
        end else begin
            r_vs  <= vs_in[r_sel];
            r_hs  <= hs_in[r_sel];
            r_rgb <= rgb_in[r_sel*RGB_W +: RGB_W];
        end
    end

    assign vs        = r_vs;
    assign hs        = r_hs;
    assign rgb       = r_rgb;
    assign state     = r_state;
    assign aim_x     = r_aim_x;
    assign aim_y     = r_aim_y;
    assign goal      = r_goal;
    assign goals     = r_goals;
    assign round_cnt = r_rounds;

endmodule

// File: tb/tb_game_screen_ctl.sv
// Directed bench for game_screen_ctl with default parameters.
module tb_game_screen_ctl;

    localparam int DEB = 4;
`ifdef MOUSE_DEBOUNCE_EN
    localparam int HOLD = DEB + 1;
`else
    localparam int HOLD = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mouse_left = 1'b0;
    logic [11:0] xpos = '0, ypos = '0, keeper_x = '0;
    logic [3:0]  vs_in = 4'h0;
    logic [3:0]  hs_in = 4'b0110;
    logic [47:0] rgb_in = {12'h444, 12'h333, 12'h222, 12'h111};
    logic        vs, hs, goal;
    logic [11:0] rgb, aim_x, aim_y;
    logic [1:0]  state;
    logic [2:0]  goals, round_cnt;

    int checks = 0;
    int errors = 0;

    game_screen_ctl dut (
        .clk(clk), .rst(rst), .mouse_left(mouse_left), .xpos(xpos), .ypos(ypos),
        .keeper_x(keeper_x), .vs_in(vs_in), .hs_in(hs_in), .rgb_in(rgb_in),
        .vs(vs), .hs(hs), .rgb(rgb), .state(state), .aim_x(aim_x), .aim_y(aim_y),
        .goal(goal), .goals(goals), .round_cnt(round_cnt)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic tick();
        vs_in = 4'hF; cyc();
        vs_in = 4'h0; cyc();
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic press();
        mouse_left = 1'b1; repeat (HOLD) cyc();
        mouse_left = 1'b0; repeat (HOLD) cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1; repeat (3) cyc();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d want 0", state); end
        checks++; if (aim_x !== 12'd0 || aim_y !== 12'd0) begin errors++; $display("FAIL rst_aim got %0d/%0d want 0/0", aim_x, aim_y); end
        checks++; if (goal !== 1'b0 || goals !== 3'd0 || round_cnt !== 3'd0) begin errors++; $display("FAIL rst_score got %0d/%0d/%0d want 0/0/0", goal, goals, round_cnt); end
        checks++; if (vs !== 1'b0 || hs !== 1'b0 || rgb !== 12'h000) begin errors++; $display("FAIL rst_video got %0b/%0b/%h want 0/0/000", vs, hs, rgb); end
        rst = 1'b0; cyc();
        checks++; if (rgb !== 12'h111 || hs !== 1'b0) begin errors++; $display("FAIL rst_src0 got %h/%0b want 111/0", rgb, hs); end
    endtask

    task automatic test_screen();
        press();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_click got %0d want 1", state); end
        checks++; if (rgb !== 12'h111) begin errors++; $display("FAIL screen_hold got %h want 111", rgb); end
        vs_in = 4'hF; cyc();
        checks++; if (rgb !== 12'h111 || vs !== 1'b1) begin errors++; $display("FAIL screen_edge got %h/%0b want 111/1", rgb, vs); end
        vs_in = 4'h0; cyc();
        checks++; if (rgb !== 12'h222 || hs !== 1'b1) begin errors++; $display("FAIL screen_aim got %h/%0b want 222/1", rgb, hs); end
    endtask

    task automatic test_goal();
        xpos = 12'd100; ypos = 12'd200; keeper_x = 12'd400;
        press();
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL aim_click got %0d want 2", state); end
        checks++; if (aim_x !== 12'd100 || aim_y !== 12'd200) begin errors++; $display("FAIL aim_latch got %0d/%0d want 100/200", aim_x, aim_y); end
        xpos = 12'd7;
        press();
        checks++; if (state !== 2'd2 || aim_x !== 12'd100) begin errors++; $display("FAIL shot_click got %0d/%0d want 2/100", state, aim_x); end
        ticks(59);
        checks++; if (state !== 2'd2 || rgb !== 12'h333) begin errors++; $display("FAIL shot_59 got %0d/%h want 2/333", state, rgb); end
        tick();
        checks++; if (state !== 2'd3 || goal !== 1'b1 || goals !== 3'd1) begin errors++; $display("FAIL shot_60 got %0d/%0d/%0d want 3/1/1", state, goal, goals); end
        ticks(119);
        checks++; if (state !== 2'd3 || round_cnt !== 3'd0 || rgb !== 12'h444) begin errors++; $display("FAIL result_119 got %0d/%0d/%h want 3/0/444", state, round_cnt, rgb); end
        tick();
        checks++; if (state !== 2'd1 || round_cnt !== 3'd1) begin errors++; $display("FAIL result_120 got %0d/%0d want 1/1", state, round_cnt); end
    endtask

    task automatic test_save();
        xpos = 12'd100; keeper_x = 12'd130;
        press(); ticks(60);
        checks++; if (state !== 2'd3 || goal !== 1'b0 || goals !== 3'd1) begin errors++; $display("FAIL save_30 got %0d/%0d/%0d want 3/0/1", state, goal, goals); end
        press();
        checks++; if (state !== 2'd1 || round_cnt !== 3'd2) begin errors++; $display("FAIL result_skip got %0d/%0d want 1/2", state, round_cnt); end
        keeper_x = 12'd148;
        press(); ticks(60);
        checks++; if (goal !== 1'b0 || goals !== 3'd1) begin errors++; $display("FAIL save_48 got %0d/%0d want 0/1", goal, goals); end
        press();
        keeper_x = 12'd149;
        press(); ticks(60);
        checks++; if (goal !== 1'b1 || goals !== 3'd2) begin errors++; $display("FAIL goal_49 got %0d/%0d want 1/2", goal, goals); end
        press();
        checks++; if (state !== 2'd1 || round_cnt !== 3'd4) begin errors++; $display("FAIL round4 got %0d/%0d want 1/4", state, round_cnt); end
    endtask

    task automatic test_rounds();
        xpos = 12'd500; keeper_x = 12'd451;
        press(); ticks(60);
        checks++; if (goal !== 1'b1 || goals !== 3'd3) begin errors++; $display("FAIL goal_rev49 got %0d/%0d want 1/3", goal, goals); end
        press();
        checks++; if (state !== 2'd0 || round_cnt !== 3'd5 || goals !== 3'd3) begin errors++; $display("FAIL game_over got %0d/%0d/%0d want 0/5/3", state, round_cnt, goals); end
        ticks(3);
        checks++; if (state !== 2'd0 || round_cnt !== 3'd5) begin errors++; $display("FAIL start_hold got %0d/%0d want 0/5", state, round_cnt); end
        press();
        checks++; if (state !== 2'd1 || round_cnt !== 3'd0 || goals !== 3'd0) begin errors++; $display("FAIL new_game got %0d/%0d/%0d want 1/0/0", state, round_cnt, goals); end
    endtask

    task automatic test_rst_mid();
        xpos = 12'd77; ypos = 12'd88;
        press(); ticks(10);
        checks++; if (state !== 2'd2 || aim_x !== 12'd77) begin errors++; $display("FAIL pre_rst got %0d/%0d want 2/77", state, aim_x); end
        mouse_left = 1'b1; rst = 1'b1; cyc();
        checks++; if (state !== 2'd0 || aim_x !== 12'd0 || aim_y !== 12'd0 || rgb !== 12'h000) begin errors++; $display("FAIL mid_rst got %0d/%0d/%0d/%h want 0/0/0/000", state, aim_x, aim_y, rgb); end
        rst = 1'b0; cyc();
        checks++; if (state !== 2'd0 || rgb !== 12'h111) begin errors++; $display("FAIL rst_release got %0d/%h want 0/111", state, rgb); end
        repeat (HOLD + 2) cyc();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL held_button got %0d want 0", state); end
        mouse_left = 1'b0; repeat (HOLD + 1) cyc();
        press();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL post_rst_click got %0d want 1", state); end
    endtask

`ifdef MOUSE_DEBOUNCE_EN
    task automatic test_debounce();
        mouse_left = 1'b1; repeat (2) cyc();
        mouse_left = 1'b0; repeat (DEB + 2) cyc();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL glitch got %0d want 1", state); end
        mouse_left = 1'b1; repeat (DEB) cyc();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL db_early got %0d want 1", state); end
        cyc();
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL db_edge got %0d want 2", state); end
        repeat (5) cyc();
        mouse_left = 1'b0; repeat (DEB + 2) cyc();
    endtask
`endif

    initial begin
        test_reset();
        test_screen();
        test_goal();
        test_save();
        test_rounds();
        test_rst_mid();
`ifdef MOUSE_DEBOUNCE_EN
        test_debounce();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
